// File: rtl/cr16_pkg.sv
// rtl/cr16_pkg.sv - shared constants for the CR16 PC/flag unit
package cr16_pkg;

    localparam int unsigned CR16_WIDTH = 16;

    // Bit positions inside the PSR {N,Z,F,L,C}
    localparam int unsigned PSR_C = 0;
    localparam int unsigned PSR_L = 1;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 3;
    localparam int unsigned PSR_N = 4;

    typedef enum logic [1:0] {
        BT_SEQ   = 2'b00,
        BT_BCOND = 2'b01,
        BT_JCOND = 2'b10,
        BT_JAL   = 2'b11
    } branch_t;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000,
        CC_NE = 4'b0001,
        CC_CS = 4'b0010,
        CC_CC = 4'b0011,
        CC_HI = 4'b0100,
        CC_LS = 4'b0101,
        CC_GT = 4'b0110,
        CC_LE = 4'b0111,
        CC_FS = 4'b1000,
        CC_FC = 4'b1001,
        CC_LO = 4'b1010,
        CC_HS = 4'b1011,
        CC_LT = 4'b1100,
        CC_GE = 4'b1101,
        CC_UC = 4'b1110,
        CC_NV = 4'b1111
    } cond_t;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition-code evaluation against the PSR
module cond_eval
    import cr16_pkg::*;
(
    input  logic [4:0] psr,
    input  logic [3:0] cond,
    output logic       taken
);

    logic flag_c, flag_l, flag_f, flag_z, flag_n;

    assign flag_c = psr[PSR_C];
    assign flag_l = psr[PSR_L];
    assign flag_f = psr[PSR_F];
    assign flag_z = psr[PSR_Z];
    assign flag_n = psr[PSR_N];

    // Decode the condition code into a single taken bit
    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            CC_EQ: taken = flag_z;
            CC_NE: taken = !flag_z;
            CC_CS: taken = flag_c;
            CC_CC: taken = !flag_c;
            CC_HI: taken = flag_l;
            CC_LS: taken = !flag_l;
            CC_GT: taken = flag_n;
            CC_LE: taken = !flag_n;
            CC_FS: taken = flag_f;
            CC_FC: taken = !flag_f;
            CC_LO: taken = !flag_l && !flag_z;
            CC_HS: taken = flag_l || flag_z;
            CC_LT: taken = !flag_n && !flag_z;
            CC_GE: taken = flag_n || flag_z;
            CC_UC: taken = 1'b1;
            CC_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// rtl/pc_flag_unit.sv - PSR latch, branch resolution and program counter
module pc_flag_unit
    import cr16_pkg::*;
#(
    parameter int unsigned      WIDTH    = CR16_WIDTH,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             aluCarry,
    input  logic             aluLow,
    input  logic             aluOverflow,
    input  logic             aluZero,
    input  logic             aluNegative,
    input  logic             flagWrite,
    input  logic             pcAdvance,
    input  logic [1:0]       branchType,
    input  logic [3:0]       cond,
    input  logic [7:0]       disp,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic [4:0]       psr,
    output logic [WIDTH-1:0] linkAddr,
    output logic             linkValid,
    output logic             redirect
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [4:0]       psr_q, psr_d;
    logic [WIDTH-1:0] link_q, link_d;
    logic             link_valid_q, link_valid_d;
    logic             redirect_q, redirect_d;

    logic             taken;
    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] disp_ext;

    // The condition always sees the PSR from before this edge, so a
    // same-cycle flagWrite cannot influence the branch it accompanies.
    cond_eval u_cond_eval (
        .psr   (psr_q),
        .cond  (cond),
        .taken (taken)
    );

    assign pc_seq   = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
    assign disp_ext = {{(WIDTH-8){disp[7]}}, disp};

    // Next-state selection for PSR, PC, link register and the two pulses
    always_comb begin
        psr_d        = psr_q;
        pc_d         = pc_q;
        link_d       = link_q;
        link_valid_d = 1'b0;
        redirect_d   = 1'b0;

        if (flagWrite) begin
            psr_d = {aluNegative, aluZero, aluOverflow, aluLow, aluCarry};
        end

        if (pcAdvance) begin
            case (branch_t'(branchType))
                BT_SEQ: begin
                    pc_d = pc_seq;
                end
                BT_BCOND: begin
                    pc_d       = taken ? (pc_q + disp_ext) : pc_seq;
                    redirect_d = taken;
                end
                BT_JCOND: begin
                    pc_d       = taken ? target : pc_seq;
                    redirect_d = taken;
                end
                BT_JAL: begin
                    pc_d         = target;
                    link_d       = pc_seq;
                    link_valid_d = 1'b1;
                    redirect_d   = 1'b1;
                end
                default: begin
                    pc_d = pc_seq;
                end
            endcase
        end
    end

    // State registers; reset drops any pending pulse immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= PC_RESET;
            psr_q        <= '0;
            link_q       <= '0;
            link_valid_q <= 1'b0;
            redirect_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            psr_q        <= psr_d;
            link_q       <= link_d;
            link_valid_q <= link_valid_d;
            redirect_q   <= redirect_d;
        end
    end

    assign pc        = pc_q;
    assign psr       = psr_q;
    assign linkAddr  = link_q;
    assign linkValid = link_valid_q;
    assign redirect  = redirect_q;

endmodule

// File: tb/tb_pc_flag_unit.sv
// tb/tb_pc_flag_unit.sv - directed self-checking bench for pc_flag_unit
module tb_pc_flag_unit;

    logic        clk;
    logic        reset;
    logic        aluCarry, aluLow, aluOverflow, aluZero, aluNegative;
    logic        flagWrite;
    logic        pcAdvance;
    logic [1:0]  branchType;
    logic [3:0]  cond;
    logic [7:0]  disp;
    logic [15:0] target;
    logic [15:0] pc;
    logic [4:0]  psr;
    logic [15:0] linkAddr;
    logic        linkValid;
    logic        redirect;

    int tests_run;
    int tests_failed;

    pc_flag_unit #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .aluCarry    (aluCarry),
        .aluLow      (aluLow),
        .aluOverflow (aluOverflow),
        .aluZero     (aluZero),
        .aluNegative (aluNegative),
        .flagWrite   (flagWrite),
        .pcAdvance   (pcAdvance),
        .branchType  (branchType),
        .cond        (cond),
        .disp        (disp),
        .target      (target),
        .pc          (pc),
        .psr         (psr),
        .linkAddr    (linkAddr),
        .linkValid   (linkValid),
        .redirect    (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input logic [1:0] bt, input logic [3:0] cc, input logic [7:0] d, input logic [15:0] tgt);
        branchType = bt;
        cond       = cc;
        disp       = d;
        target     = tgt;
        pcAdvance  = 1'b1;
        tick();
        pcAdvance  = 1'b0;
        branchType = 2'b00;
        cond       = 4'h0;
        disp       = 8'h00;
        target     = 16'h0000;
    endtask

    task automatic write_flags(input logic [4:0] p);
        {aluNegative, aluZero, aluOverflow, aluLow, aluCarry} = p;
        flagWrite = 1'b1;
        tick();
        flagWrite = 1'b0;
        {aluNegative, aluZero, aluOverflow, aluLow, aluCarry} = 5'b0;
    endtask

    task automatic jump_to(input logic [15:0] a);
        advance(2'b10, 4'hE, 8'h00, a);
    endtask

    function automatic logic exp_taken(input logic [4:0] p, input logic [3:0] c);
        logic n, z, f, l, cy;
        n = p[4]; z = p[3]; f = p[2]; l = p[1]; cy = p[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return l;
            4'h5: return !l;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return f;
            4'h9: return !f;
            4'hA: return !l && !z;
            4'hB: return l || z;
            4'hC: return !n && !z;
            4'hD: return n || z;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [4:0] patterns [6];

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        {aluNegative, aluZero, aluOverflow, aluLow, aluCarry} = 5'b0;
        flagWrite  = 1'b0;
        pcAdvance  = 1'b0;
        branchType = 2'b00;
        cond       = 4'h0;
        disp       = 8'h00;
        target     = 16'h0000;

        // Reset state
        #1;
        check("rst_pc", pc, 16'h0000);
        check("rst_psr", {11'b0, psr}, 16'h0000);
        check("rst_link", linkAddr, 16'h0000);
        check("rst_linkvalid", {15'b0, linkValid}, 16'h0000);
        check("rst_redirect", {15'b0, redirect}, 16'h0000);
        tick();
        reset = 1'b0;

        // Mid-cycle reset with pc=0x0042 and a redirect pulse pending
        write_flags(5'b10101);
        jump_to(16'h0042);
        check("pre_rst_pc", pc, 16'h0042);
        check("pre_rst_redirect", {15'b0, redirect}, 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc", pc, 16'h0000);
        check("async_rst_psr", {11'b0, psr}, 16'h0000);
        check("async_rst_redirect", {15'b0, redirect}, 16'h0000);
        #1;
        reset = 1'b0;
        advance(2'b00, 4'h0, 8'h00, 16'h0000);
        advance(2'b00, 4'h0, 8'h00, 16'h0000);
        advance(2'b00, 4'h0, 8'h00, 16'h0000);
        check("seq3_pc", pc, 16'h0003);

        // Hold when pcAdvance=0, even with junk on branch inputs
        branchType = 2'b11; cond = 4'hE; disp = 8'h80; target = 16'hAAAA;
        tick();
        check("hold_pc", pc, 16'h0003);
        check("hold_link", linkAddr, 16'h0000);
        check("hold_redirect", {15'b0, redirect}, 16'h0000);

        // Flags and BCOND
        write_flags(5'b01000);
        check("psr_zero", {11'b0, psr}, 16'h0008);
        jump_to(16'h0010);
        advance(2'b01, 4'h0, 8'hFC, 16'h0000);
        check("bcond_eq_pc", pc, 16'h000C);
        check("bcond_eq_redirect", {15'b0, redirect}, 16'h0001);
        tick();
        check("bcond_eq_redirect_once", {15'b0, redirect}, 16'h0000);
        jump_to(16'h0010);
        advance(2'b01, 4'h1, 8'hFC, 16'h0000);
        check("bcond_ne_pc", pc, 16'h0011);
        check("bcond_ne_redirect", {15'b0, redirect}, 16'h0000);

        // Same-cycle flagWrite and branch: branch sees old Z
        write_flags(5'b00000);
        jump_to(16'h0020);
        aluZero   = 1'b1;
        flagWrite = 1'b1;
        advance(2'b01, 4'h0, 8'h05, 16'h0000);
        flagWrite = 1'b0;
        aluZero   = 1'b0;
        check("hazard_pc", pc, 16'h0021);
        check("hazard_redirect", {15'b0, redirect}, 16'h0000);
        check("hazard_psr", {11'b0, psr}, 16'h0008);

        // JAL
        jump_to(16'h1234);
        advance(2'b11, 4'hF, 8'h00, 16'h0400);
        check("jal_pc", pc, 16'h0400);
        check("jal_link", linkAddr, 16'h1235);
        check("jal_linkvalid", {15'b0, linkValid}, 16'h0001);
        check("jal_redirect", {15'b0, redirect}, 16'h0001);
        tick();
        check("jal_linkvalid_once", {15'b0, linkValid}, 16'h0000);
        check("jal_redirect_once", {15'b0, redirect}, 16'h0000);
        check("jal_link_hold", linkAddr, 16'h1235);

        // Wrap-around
        jump_to(16'hFFFF);
        advance(2'b00, 4'h0, 8'h00, 16'h0000);
        check("wrap_seq_pc", pc, 16'h0000);
        advance(2'b01, 4'hE, 8'hFF, 16'h0000);
        check("wrap_bcond_pc", pc, 16'hFFFF);
        check("wrap_bcond_redirect", {15'b0, redirect}, 16'h0001);
        advance(2'b11, 4'h0, 8'h00, 16'h0100);
        check("wrap_jal_link", linkAddr, 16'h0000);
        check("wrap_jal_pc", pc, 16'h0100);

        // Condition sweep with JCOND target 0xBEEF
        patterns[0] = 5'b00000;
        patterns[1] = 5'b11111;
        patterns[2] = 5'b01000;
        patterns[3] = 5'b00010;
        patterns[4] = 5'b10000;
        patterns[5] = 5'b00101;
        for (int p = 0; p < 6; p++) begin
            write_flags(patterns[p]);
            for (int c = 0; c < 16; c++) begin
                jump_to(16'h1000);
                advance(2'b10, 4'(c), 8'h00, 16'hBEEF);
                check($sformatf("sweep_pc_p%0h_c%0h", patterns[p], c), pc,
                      exp_taken(patterns[p], 4'(c)) ? 16'hBEEF : 16'h1001);
                check($sformatf("sweep_redirect_p%0h_c%0h", patterns[p], c), {15'b0, redirect},
                      {15'b0, exp_taken(patterns[p], 4'(c))});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
